// File: rtl/ovl_frame_responder.sv
// Frame stimulus responder: after each rising edge of start_event it emits one
// test_expr pulse a (normally window-clamped) number of enabled cycles later.
module ovl_frame_responder #(
    parameter int MIN_CKS             = 0,
    parameter int MAX_CKS             = 0,
    parameter int ACTION_ON_NEW_START = 0,
    parameter int DW                  = 8,
    parameter int ALLOW_VIOLATE       = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start_event,
    input  logic [DW-1:0] delay_sel,
    output logic          test_expr,
    output logic          busy,
    output logic          clamped,
    output logic          collision,
    output logic          err_new_start
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [DW-1:0] ONE_D = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] LO_D  = (MIN_CKS == 32'sd0) ? ONE_D : DW'(MIN_CKS);
    localparam logic [DW-1:0] HI_D  = (MAX_CKS == 32'sd0) ? {DW{1'b1}} : DW'(MAX_CKS);

    // A zero request always becomes one cycle so the down-counter can never wrap.
    function automatic logic [DW-1:0] eff_delay(input logic [DW-1:0] sel);
        logic [DW-1:0] d;
        if (ALLOW_VIOLATE != 32'sd0) begin
            d = (sel == {DW{1'b0}}) ? ONE_D : sel;
        end else if (sel < LO_D) begin
            d = LO_D;
        end else if (sel > HI_D) begin
            d = HI_D;
        end else begin
            d = sel;
        end
        return d;
    endfunction

    function automatic logic is_clamped(input logic [DW-1:0] sel, input logic [DW-1:0] d);
        return (d != sel) && !((sel == {DW{1'b0}}) && (d == ONE_D));
    endfunction

    state_t        state_r;
    logic [DW-1:0] cnt_r;
    logic          start_q_r;
    logic          clamp_pend_r;
    logic          coll_pend_r;
    logic          err_pend_r;

    logic          edge_s;
    logic [DW-1:0] d_s;
    logic          clamp_s;

    // Start-edge detection and effective delay for a frame accepted this cycle.
    always_comb begin
        edge_s  = enable & start_event & ~start_q_r;
        d_s     = eff_delay(delay_sel);
        clamp_s = is_clamped(delay_sel, d_s);
    end

    // Frame FSM; status flags are presented one cycle after the event that raised them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {DW{1'b0}};
            start_q_r     <= 1'b0;
            clamp_pend_r  <= 1'b0;
            coll_pend_r   <= 1'b0;
            err_pend_r    <= 1'b0;
            test_expr     <= 1'b0;
            busy          <= 1'b0;
            clamped       <= 1'b0;
            collision     <= 1'b0;
            err_new_start <= 1'b0;
        end else begin
            busy          <= (state_r == ST_WAIT);
            clamped       <= clamp_pend_r;
            collision     <= coll_pend_r;
            err_new_start <= err_pend_r;
            test_expr     <= 1'b0;
            clamp_pend_r  <= 1'b0;
            coll_pend_r   <= 1'b0;
            err_pend_r    <= 1'b0;
            if (enable) begin
                start_q_r <= start_event;
                case (state_r)
                    ST_IDLE: begin
                        if (edge_s) begin
                            state_r      <= ST_WAIT;
                            cnt_r        <= d_s - ONE_D;
                            clamp_pend_r <= clamp_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_r == {DW{1'b0}}) begin
                            test_expr <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r - ONE_D;
                        end
                        // A restart overrides the expiry above, so a coincident pulse still fires.
                        if (edge_s) begin
                            coll_pend_r <= 1'b1;
                            if (ACTION_ON_NEW_START == 32'sd1) begin
                                state_r      <= ST_WAIT;
                                cnt_r        <= d_s - ONE_D;
                                clamp_pend_r <= clamp_s;
                            end else if (ACTION_ON_NEW_START == 32'sd2) begin
                                err_pend_r <= 1'b1;
                            end else begin
                                err_pend_r <= 1'b0;
                            end
                        end else begin
                            coll_pend_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {DW{1'b0}};
                    end
                endcase
            end else begin
                state_r   <= state_r;
                cnt_r     <= cnt_r;
                start_q_r <= start_q_r;
            end
        end
    end

endmodule
